// File: rtl/timer_clint.sv
// Machine timer (CLINT-style): prescaled 64-bit mtime, mtimecmp compare and a
// single-cycle-response memory port. Registers are reached through mem_addr[4:2].
//   state    | meaning
//   ST_IDLE  | ready to accept a request
//   ST_RESP  | mem_ready/mem_rdata presented for exactly one cycle
module timer_clint #(
   parameter int unsigned TIM_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        timer_irpt
);

   typedef enum logic {ST_IDLE, ST_RESP} state_e;

   localparam logic [15:0] PRESC_LAST = 16'(TIM_DIV - 1);

   state_e      state_q, state_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        ctrl_en_q, ctrl_en_d;
   logic [15:0] presc_q, presc_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irpt_q, irpt_d;

   logic        accept;
   logic        wr_en;
   logic        tick;
   logic [2:0]  offset;
   logic [31:0] reg_rd;
   logic [31:0] wr_val;
   logic        unused_addr;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   assign unused_addr = ^{mem_addr[31:5], mem_addr[1:0]};

   assign accept = mem_valid && (state_q == ST_IDLE);
   assign wr_en  = accept && (mem_wstrb != 4'b0000);
   assign offset = mem_addr[4:2];
   assign tick   = ctrl_en_q && (presc_q == PRESC_LAST);

   always_comb begin
      reg_rd = '0;
      case (offset)
         3'd0:    reg_rd = mtime_q[31:0];
         3'd1:    reg_rd = mtime_q[63:32];
         3'd2:    reg_rd = mtimecmp_q[31:0];
         3'd3:    reg_rd = mtimecmp_q[63:32];
         3'd4:    reg_rd = {31'b0, ctrl_en_q};
         default: reg_rd = '0;
      endcase
   end

   assign wr_val = merge_bytes(reg_rd, mem_wdata, mem_wstrb);

   always_comb begin
      state_d    = accept ? ST_RESP : ST_IDLE;
      presc_d    = presc_q;
      if (ctrl_en_q) presc_d = tick ? 16'd0 : presc_q + 16'd1;
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      ctrl_en_d  = ctrl_en_q;
      rdata_d    = '0;
      if (accept && !wr_en) rdata_d = reg_rd;
      // a bus write to either mtime half overrides that cycle's increment
      if (wr_en) begin
         case (offset)
            3'd0:    mtime_d = {mtime_q[63:32], wr_val};
            3'd1:    mtime_d = {wr_val, mtime_q[31:0]};
            3'd2:    mtimecmp_d[31:0]  = wr_val;
            3'd3:    mtimecmp_d[63:32] = wr_val;
            3'd4:    ctrl_en_d = wr_val[0];
            default: ;
         endcase
      end
      irpt_d = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         ctrl_en_q  <= 1'b1;
         presc_q    <= '0;
         rdata_q    <= '0;
         irpt_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         ctrl_en_q  <= ctrl_en_d;
         presc_q    <= presc_d;
         rdata_q    <= rdata_d;
         irpt_q     <= irpt_d;
      end
   end

   assign mem_ready  = (state_q == ST_RESP);
   assign mem_rdata  = rdata_q;
   assign timer_irpt = irpt_q;

endmodule
